// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath
//
// 8-bit register-transfer datapath for the CDEC-V core. Each rising clock
// edge performs one register transfer: xsrc gates a source onto the
// internal X bus, every register whose xdst bit is set loads in that same
// edge, and the ALU computes a result and flags from X (operand P) and
// T (operand Q).
//
// Control contract: there is no handshake. xsrc/xdst/aluop form a
// per-cycle command that the controller changes after the falling edge
// and holds stable through the next rising edge, where it is consumed
// unconditionally.
//
// Ports
//   clock      in   system clock, registers load on the rising edge
//   reset_n    in   asynchronous active-low reset, clears all registers
//   xsrc       in   X source: 7=FF 6=FLG 5=R 4=RD 3=C 2=B 1=A 0=PC
//   xdst       in   load enables: 9 FLG 8 R 7 T 6 I 5 WD 4 MA 3 C 2 B 1 A 0 PC
//   aluop      in   ALU operation (0 PASS .. 9 DEC, 10-15 PASS)
//   mem_rdata  in   memory read data RD, combinational from mem_addr
//   I          out  instruction register
//   SZCy       out  flag register {S, Z, Cy}
//   mem_addr   out  MA register
//   mem_wdata  out  WD register
//   pc_out, a_out, b_out, c_out  out  monitor copies of PC, A, B, C
// ---------------------------------------------------------------------------
module datapath (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] xsrc,
    input  logic [9:0] xdst,
    input  logic [3:0] aluop,
    input  logic [7:0] mem_rdata,
    output logic [7:0] I,
    output logic [2:0] SZCy,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic [7:0] pc_out,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic [7:0] c_out
);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_SBB = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_EOR = 4'd7;
    localparam logic [3:0] OP_INC = 4'd8;
    localparam logic [3:0] OP_DEC = 4'd9;

    logic [7:0] pc_q, a_q, b_q, c_q, ma_q, wd_q, i_q, t_q, r_q;
    logic [2:0] flg_q;
    logic [7:0] pc_d, a_d, b_d, c_d, ma_d, wd_d, i_d, t_d, r_d;
    logic [2:0] flg_d;

    logic [7:0] x_bus;
    logic [8:0] p9, q9, sum9;
    logic [8:0] cin9;
    logic [7:0] alu_res;
    logic [2:0] alu_flags;

    // X bus source mux
    always_comb begin
        x_bus = 8'hFF;
        case (xsrc)
            3'd0:    x_bus = pc_q;
            3'd1:    x_bus = a_q;
            3'd2:    x_bus = b_q;
            3'd3:    x_bus = c_q;
            3'd4:    x_bus = mem_rdata;
            3'd5:    x_bus = r_q;
            3'd6:    x_bus = {5'b00000, flg_q};
            default: x_bus = 8'hFF;
        endcase
    end

    // ALU. Everything is done in 9 bits so that bit 8 is the carry for
    // additions and, through two's-complement wrap, the borrow for
    // subtractions. Logic ops and PASS leave bit 8 at zero, so the carry
    // flag is simply sum9[8] for every operation.
    always_comb begin
        p9   = {1'b0, x_bus};
        q9   = {1'b0, t_q};
        cin9 = {8'd0, flg_q[0]};
        sum9 = p9;
        case (aluop)
            OP_ADD:  sum9 = p9 + q9;
            OP_ADC:  sum9 = p9 + q9 + cin9;
            OP_SUB:  sum9 = p9 - q9;
            OP_SBB:  sum9 = p9 - q9 - cin9;
            OP_AND:  sum9 = {1'b0, x_bus & t_q};
            OP_OR:   sum9 = {1'b0, x_bus | t_q};
            OP_EOR:  sum9 = {1'b0, x_bus ^ t_q};
            OP_INC:  sum9 = p9 + 9'd1;
            OP_DEC:  sum9 = p9 - 9'd1;
            default: sum9 = p9;
        endcase
        alu_res   = sum9[7:0];
        alu_flags = {alu_res[7], (alu_res == 8'h00), sum9[8]};
    end

    // Next-state: every register holds unless its enable is set. All
    // enables act on values sampled before the edge, so a register used
    // as both source and destination simply reloads itself.
    always_comb begin
        pc_d  = xdst[0] ? x_bus     : pc_q;
        a_d   = xdst[1] ? x_bus     : a_q;
        b_d   = xdst[2] ? x_bus     : b_q;
        c_d   = xdst[3] ? x_bus     : c_q;
        ma_d  = xdst[4] ? x_bus     : ma_q;
        wd_d  = xdst[5] ? x_bus     : wd_q;
        i_d   = xdst[6] ? x_bus     : i_q;
        t_d   = xdst[7] ? x_bus     : t_q;
        r_d   = xdst[8] ? alu_res   : r_q;
        flg_d = xdst[9] ? alu_flags : flg_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= 8'h00;
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            c_q   <= 8'h00;
            ma_q  <= 8'h00;
            wd_q  <= 8'h00;
            i_q   <= 8'h00;
            t_q   <= 8'h00;
            r_q   <= 8'h00;
            flg_q <= 3'b000;
        end else begin
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            ma_q  <= ma_d;
            wd_q  <= wd_d;
            i_q   <= i_d;
            t_q   <= t_d;
            r_q   <= r_d;
            flg_q <= flg_d;
        end
    end

    assign I         = i_q;
    assign SZCy      = flg_q;
    assign mem_addr  = ma_q;
    assign mem_wdata = wd_q;
    assign pc_out    = pc_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign c_out     = c_q;

endmodule

// File: tb/tb_datapath.sv
// ---------------------------------------------------------------------------
// tb_datapath
//
// Bench for the datapath. The bench owns the memory (combinational read
// addressed by mem_addr) and keeps an architectural model of all ten
// registers. Each driven command pushes the expected visible state onto
// exp_q; after the rising edge the entry is popped and compared against
// the DUT outputs. Hidden registers R and T are observed by moving them
// through visible ones.
// ---------------------------------------------------------------------------
module tb_datapath;

    localparam int EXP_W = 59;

    localparam logic [9:0] D_PC  = 10'h001;
    localparam logic [9:0] D_A   = 10'h002;
    localparam logic [9:0] D_B   = 10'h004;
    localparam logic [9:0] D_C   = 10'h008;
    localparam logic [9:0] D_MA  = 10'h010;
    localparam logic [9:0] D_WD  = 10'h020;
    localparam logic [9:0] D_I   = 10'h040;
    localparam logic [9:0] D_T   = 10'h080;
    localparam logic [9:0] D_R   = 10'h100;
    localparam logic [9:0] D_FLG = 10'h200;

    // clock / reset ---------------------------------------------------------
    logic       clock;
    logic       reset_n;
    logic [2:0] xsrc;
    logic [9:0] xdst;
    logic [3:0] aluop;
    logic [7:0] mem_rdata;
    logic [7:0] I;
    logic [2:0] SZCy;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] pc_out, a_out, b_out, c_out;

    logic [7:0] mem [256];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always_comb mem_rdata = mem[mem_addr];

    datapath dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .xsrc      (xsrc),
        .xdst      (xdst),
        .aluop     (aluop),
        .mem_rdata (mem_rdata),
        .I         (I),
        .SZCy      (SZCy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .pc_out    (pc_out),
        .a_out     (a_out),
        .b_out     (b_out),
        .c_out     (c_out)
    );

    // scoreboard ------------------------------------------------------------
    int checks   = 0;
    int failures = 0;
    logic [EXP_W-1:0] exp_q[$];

    logic [7:0] m_pc, m_a, m_b, m_c, m_ma, m_wd, m_i, m_t, m_r;
    logic [2:0] m_flg;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00; m_c = 8'h00;
        m_ma = 8'h00; m_wd = 8'h00; m_i = 8'h00; m_t = 8'h00;
        m_r = 8'h00; m_flg = 3'b000;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".pc"},   pc_out,    0);
        check_eq({tag, ".a"},    a_out,     0);
        check_eq({tag, ".b"},    b_out,     0);
        check_eq({tag, ".c"},    c_out,     0);
        check_eq({tag, ".ma"},   mem_addr,  0);
        check_eq({tag, ".wd"},   mem_wdata, 0);
        check_eq({tag, ".i"},    I,         0);
        check_eq({tag, ".szcy"}, SZCy,      0);
    endtask

    // driver: one register transfer ------------------------------------------
    task automatic step(input string tag, input logic [2:0] s, input logic [9:0] d,
                        input logic [3:0] op);
        logic [7:0] x, res;
        logic [EXP_W-1:0] e;
        int p, q, v;
        logic cy;
        @(negedge clock);
        xsrc  = s;
        xdst  = d;
        aluop = op;
        case (s)
            3'd0: x = m_pc;
            3'd1: x = m_a;
            3'd2: x = m_b;
            3'd3: x = m_c;
            3'd4: x = mem[m_ma];
            3'd5: x = m_r;
            3'd6: x = {5'b00000, m_flg};
            default: x = 8'hFF;
        endcase
        p = int'(x);
        q = int'(m_t);
        case (op)
            4'd1: v = p + q;
            4'd2: v = p + q + int'(m_flg[0]);
            4'd3: v = p - q;
            4'd4: v = p - q - int'(m_flg[0]);
            4'd5: v = p & q;
            4'd6: v = p | q;
            4'd7: v = p ^ q;
            4'd8: v = p + 1;
            4'd9: v = p - 1;
            default: v = p;
        endcase
        cy  = (v > 255) || (v < 0);
        res = 8'(v & 255);
        if (d[0]) m_pc = x;
        if (d[1]) m_a  = x;
        if (d[2]) m_b  = x;
        if (d[3]) m_c  = x;
        if (d[4]) m_ma = x;
        if (d[5]) m_wd = x;
        if (d[6]) m_i  = x;
        if (d[7]) m_t  = x;
        if (d[8]) m_r  = res;
        if (d[9]) m_flg = {res[7], (res == 8'h00), cy};
        exp_q.push_back({m_pc, m_a, m_b, m_c, m_ma, m_wd, m_i, m_flg});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, ".pc"},   pc_out,    e[58:51]);
        check_eq({tag, ".a"},    a_out,     e[50:43]);
        check_eq({tag, ".b"},    b_out,     e[42:35]);
        check_eq({tag, ".c"},    c_out,     e[34:27]);
        check_eq({tag, ".ma"},   mem_addr,  e[26:19]);
        check_eq({tag, ".wd"},   mem_wdata, e[18:11]);
        check_eq({tag, ".i"},    I,         e[10:3]);
        check_eq({tag, ".szcy"}, SZCy,      e[2:0]);
    endtask

    // load a constant into the enabled registers through the memory port
    task automatic put(input string tag, input logic [7:0] val, input logic [9:0] d);
        mem[m_ma] = val;
        step(tag, 3'd4, d, 4'd0);
    endtask

    // an ALU op of a with t into R and FLG, then R copied to A
    task automatic alu_case(input string tag, input logic [7:0] av, input logic [7:0] tv,
                            input logic [3:0] op, input logic [7:0] exp_r,
                            input logic [2:0] exp_f);
        put({tag, ".lda"}, av, D_A);
        put({tag, ".ldt"}, tv, D_T);
        step({tag, ".op"}, 3'd1, D_R | D_FLG, op);
        check_eq({tag, ".flags"}, SZCy, exp_f);
        step({tag, ".mvr"}, 3'd5, D_A, 4'd0);
        check_eq({tag, ".result"}, a_out, exp_r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));

        // reset held with every enable active
        reset_n = 1'b0;
        xsrc    = 3'd7;
        xdst    = 10'h3FF;
        aluop   = 4'd0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        xdst    = 10'h000;
        reset_n = 1'b1;

        step("ff_all", 3'd7, 10'h00F, 4'd0);
        check_eq("ff_all.pc_const", pc_out, 8'hFF);
        check_eq("ff_all.c_const",  c_out,  8'hFF);

        // transfers
        put("xfer.lda", 8'h5A, D_A);
        step("xfer.mv", 3'd1, D_B | D_MA, 4'd0);
        check_eq("xfer.b_const",  b_out,    8'h5A);
        check_eq("xfer.ma_const", mem_addr, 8'h5A);
        check_eq("xfer.pc_hold",  pc_out,   8'hFF);
        check_eq("xfer.c_hold",   c_out,    8'hFF);
        step("xfer.wd", 3'd1, D_WD, 4'd0);
        check_eq("xfer.wd_const", mem_wdata, 8'h5A);
        step("self_ref", 3'd1, D_A, 4'd0);

        // ALU table
        alu_case("add",   8'hF0, 8'h20, 4'd1, 8'h10, 3'b001);
        alu_case("adc",   8'h01, 8'h01, 4'd2, 8'h03, 3'b000);
        alu_case("sub",   8'h10, 8'h20, 4'd3, 8'hF0, 3'b101);
        alu_case("sbb",   8'h10, 8'h05, 4'd4, 8'h0A, 3'b000);
        alu_case("subz",  8'h33, 8'h33, 4'd3, 8'h00, 3'b010);
        alu_case("and",   8'hF0, 8'h0F, 4'd5, 8'h00, 3'b010);
        alu_case("or",    8'h81, 8'h02, 4'd6, 8'h83, 3'b100);
        alu_case("eor",   8'hAA, 8'hFF, 4'd7, 8'h55, 3'b000);
        alu_case("dec0",  8'h00, 8'h00, 4'd9, 8'hFF, 3'b101);
        alu_case("inc",   8'h7F, 8'h00, 4'd8, 8'h80, 3'b100);
        alu_case("pass12",8'h3C, 8'h11, 4'd12, 8'h3C, 3'b000);
        step("flg_src", 3'd6, D_B, 4'd0);
        check_eq("flg_src.b", b_out, 8'h00);

        // fetch sequence
        put("fetch.pc0", 8'h00, D_PC);
        mem[0] = 8'h21;
        step("fetch.ma", 3'd0, D_MA, 4'd0);
        step("fetch.ir", 3'd4, D_I, 4'd0);
        step("fetch.inc", 3'd0, D_R, 4'd8);
        step("fetch.pc", 3'd5, D_PC, 4'd0);
        check_eq("fetch.i_const",  I,      8'h21);
        check_eq("fetch.pc_const", pc_out, 8'h01);

        put("pcwrap.ld", 8'hFF, D_PC);
        step("pcwrap.inc", 3'd0, D_R | D_FLG, 4'd8);
        step("pcwrap.pc", 3'd5, D_PC, 4'd0);
        check_eq("pcwrap.pc_const", pc_out, 8'h00);
        check_eq("pcwrap.szcy",     SZCy,   3'b011);

        // random transfers
        for (int k = 0; k < 60; k++) begin
            mem[$urandom_range(0, 255)] = 8'($urandom_range(0, 255));
            step("rnd", 3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)),
                 4'($urandom_range(0, 15)));
        end

        // reset in the middle of an R,FLG load
        alu_case("pre_rst", 8'hF0, 8'h20, 4'd1, 8'h10, 3'b001);
        step("pre_rst.ld", 3'd1, D_R | D_FLG | D_PC, 4'd1);
        @(negedge clock);
        xsrc  = 3'd1;
        xdst  = D_R | D_FLG | D_A;
        aluop = 4'd1;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst.now");
        @(posedge clock);
        #1;
        check_all_zero("midrst.edge");
        @(negedge clock);
        xdst    = 10'h000;
        reset_n = 1'b1;
        model_reset();
        step("midrst.r", 3'd5, D_A, 4'd0);
        check_eq("midrst.r_zero", a_out, 8'h00);
        step("midrst.t", 3'd7, D_B, 4'd5);
        step("midrst.t2", 3'd7, D_R | D_FLG, 4'd5);
        step("midrst.t3", 3'd5, D_C, 4'd0);
        check_eq("midrst.t_zero", c_out, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath.md
# datapath

8-bit register-transfer datapath for the CDEC-V core. It sits directly downstream of the controller and executes one register transfer per clock: it gates one source onto the internal X bus, loads the enabled destinations, and computes ALU results and flags. It feeds the current instruction (`I`) and flags (`SZCy`) back to the controller. It also drives the address and write-data lines of the instruction/data memory and exposes its architectural registers to the board monitor.

## Interface
- No parameters; the data width is fixed at 8 bits.
- `clock`  in  1  System clock. Datapath registers load on the rising edge; the controller advances on the falling edge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `xsrc`  in  3  X-bus source select: 7 = 8'hFF, 6 = FLG, 5 = R, 4 = RD, 3 = C, 2 = B, 1 = A, 0 = PC.
- `xdst`  in  10  Write enables, one bit per register: 9 FLG, 8 R, 7 T, 6 I, 5 WD, 4 MA, 3 C, 2 B, 1 A, 0 PC.
- `aluop`  in  4  ALU operation select.
- `mem_rdata`  in  8  Memory read data (RD). Combinational, addressed by MA.
- `I`  out  8  Instruction register, to the controller.
- `SZCy`  out  3  Flag register {S, Z, Cy}, to the controller.
- `mem_addr`  out  8  Equals MA.
- `mem_wdata`  out  8  Equals WD.
- `pc_out`, `a_out`, `b_out`, `c_out`  out  8 each  Monitor copies of PC, A, B and C.

## Operation
- X bus: a combinational mux driven by `xsrc`. FLG as a source reads as {5'b0, S, Z, Cy}.
- PC, A, B, C, MA, WD, I and T load the X bus when their `xdst` bit is 1. Otherwise they hold.
- R loads the ALU result when `xdst[8]` is 1.
- FLG loads the ALU flags when `xdst[9]` is 1.
- Any number of `xdst` bits may be set together. Each enabled register loads in the same edge. This is the normal case for "R and FLG <- ALU".
- ALU: operand P is the X bus, operand Q is T, and Cy is the current FLG carry. All arithmetic is 9-bit with the result taken modulo 256.
  - 0 PASS: P.
  - 1 ADD: P+Q.
  - 2 ADC: P+Q+Cy.
  - 3 SUB: P−Q.
  - 4 SBB: P−Q−Cy.
  - 5 AND: P&Q.
  - 6 OR: P|Q.
  - 7 EOR: P^Q.
  - 8 INC: P+1.
  - 9 DEC: P−1.
  - 10–15: behave as PASS.
- Flags:
  - S = result[7].
  - Z = (result == 0).
  - Cy = bit 8 of the 9-bit sum for add-type ops (1, 2, 8).
  - Cy = borrow for subtract-type ops (3, 4, 9): 1 when the true difference is negative.
  - Cy = 0 for logic and PASS ops.
- Canonical controller sequences this block must support:
  - Fetch: `xsrc`=PC, MA←X; then I←RD with `xsrc`=RD; PC increment as R←PC+1 then PC←R, or in the same cycle as a direct load.
  - ADD: T←reg; then R,FLG←A+T; then A←R.
  - LD/ST: a memory operand travels via MA, RD and WD.
- `we` does not pass through this block. Memory writes use `mem_addr` and `mem_wdata` as registered here.

## Timing
- Reset: while `reset_n` = 0, all ten registers are 0 immediately and asynchronously. Consequently `I`=0, `SZCy`=3'b000, `mem_addr`=0, `mem_wdata`=0, and all monitor outputs are 0.
- Release of `reset_n` is honoured at the next rising edge. It is synchronised externally.
- Control inputs change after the falling edge and are stable before the rising edge. The datapath samples them at the rising edge.
- Every transfer completes in exactly one clock: a value on the X bus at rising edge n is visible at the destination's output after edge n.
- ALU and flag paths are combinational from X and T to the R/FLG inputs. There is no pipeline, and no extra latency beyond the one-edge load.
- ADC/SBB use the Cy held in FLG before the edge. The new Cy is visible only after that edge.
- Self-reference: when a register is both source and destination (e.g. `xsrc`=A, `xdst[1]`=1), it reloads its own value.
- Wrap-around:
  - INC of 8'hFF → 8'h00, Z=1, Cy=1.
  - DEC of 8'h00 → 8'hFF, S=1, Cy=1.
- Reset asserted mid-instruction clears all registers at once, regardless of the enables. No partial transfer survives.

## Test plan
- Reset: hold `reset_n`=0 with `xdst`=10'h3FF and `xsrc`=7 → all outputs remain 0. Release, then one edge with `xdst`=10'h00F, `xsrc`=7 → PC, A, B and C all read 8'hFF.
- Transfers: A←8'h5A via the FF/ALU path, then `xsrc`=A with `xdst`=B|MA → after one edge, B=8'h5A and `mem_addr`=8'h5A; PC and C unchanged.
- ADD/ADC: A=8'hF0, T=8'h20, aluop 1, `xdst`=R|FLG → R=8'h10, SZCy=3'b001. Then ADC of A=8'h01, T=8'h01 → R=8'h03, SZCy=3'b001 → 3'b000.
- SUB/SBB and logic:
  - 8'h10−8'h20 → R=8'hF0, SZCy=3'b101.
  - 8'h33−8'h33 → R=8'h00, SZCy=3'b010.
  - AND 8'hF0 with 8'h0F → R=0, SZCy=3'b010.
  - EOR 8'hAA with 8'hFF → R=8'h55, SZCy=3'b000.
- Fetch with memory model: PC=8'h00, mem[0]=8'h21 → MA←PC; I←RD; R←PC+1 (INC); PC←R → I=8'h21 and PC=8'h01 after 4 edges. PC=8'hFF with INC → PC=8'h00 and Cy=1.
- Mid-operation reset: assert `reset_n`=0 between the falling and rising edges during an R,FLG load → R=0 and FLG=0 immediately, and they stay 0 through the next edge.
